// File: rtl/cmd_regfile.sv
// -----------------------------------------------------------------------------
// cmd_regfile
//   Command-driven register file for a bank of oscillator channels. A command
//   (opcode + channel index + data word) is taken in IDLE, executed for one
//   cycle in EXEC, and a READ is answered from RESP with a valid/ready
//   handshake. Writes land in shadow registers and are copied to the active
//   outputs by COMMIT. With AUTO_COMMIT set, writes update the active outputs
//   directly.
//
// Ports
//   sys_clk, sys_rst     : clock (rising edge), async active-high reset
//   cmd_word [7:0]       : [7:4] opcode, [3:0] channel index
//   data_word            : command payload
//   cmd_valid/cmd_ready  : command handshake (ready only in IDLE)
//   osc_en/tune/wave/pw  : active per-channel fields, channel i at slice i
//   modulation_select    : active global modulation select
//   rd_data/rd_valid     : readback response, held until rd_ready
//   rd_ready             : readback consumed
//   cmd_err              : one-cycle pulse for an illegal command
// -----------------------------------------------------------------------------
module cmd_regfile #(
   parameter int N_OSC                   = 2,
   parameter int DATAWORD_WIDTH          = 16,
   parameter int TUNING_WIDTH            = 14,
   parameter int WAVE_SELECT_WIDTH       = 3,
   parameter int PULSEWIDTH_WIDTH        = 12,
   parameter int MODULATION_SELECT_WIDTH = 2,
   parameter int AUTO_COMMIT             = 0
) (
   input  logic                                 sys_clk,
   input  logic                                 sys_rst,
   input  logic [7:0]                           cmd_word,
   input  logic [DATAWORD_WIDTH-1:0]            data_word,
   input  logic                                 cmd_valid,
   output logic                                 cmd_ready,
   output logic [N_OSC-1:0]                     osc_en,
   output logic [N_OSC*TUNING_WIDTH-1:0]        osc_tune,
   output logic [N_OSC*WAVE_SELECT_WIDTH-1:0]   osc_wave,
   output logic [N_OSC*PULSEWIDTH_WIDTH-1:0]    osc_pw,
   output logic [MODULATION_SELECT_WIDTH-1:0]   modulation_select,
   output logic [DATAWORD_WIDTH-1:0]            rd_data,
   output logic                                 rd_valid,
   input  logic                                 rd_ready,
   output logic                                 cmd_err
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_EXEC = 2'd1;
   localparam logic [1:0] ST_RESP = 2'd2;

   localparam logic [3:0] OP_NOP      = 4'd0;
   localparam logic [3:0] OP_SET_TUNE = 4'd1;
   localparam logic [3:0] OP_SET_WAVE = 4'd2;
   localparam logic [3:0] OP_SET_PW   = 4'd3;
   localparam logic [3:0] OP_SET_EN   = 4'd4;
   localparam logic [3:0] OP_SET_MOD  = 4'd5;
   localparam logic [3:0] OP_READ     = 4'd6;
   localparam logic [3:0] OP_COMMIT   = 4'd7;

   localparam logic [2:0] SEL_TUNE = 3'd0;
   localparam logic [2:0] SEL_WAVE = 3'd1;
   localparam logic [2:0] SEL_PW   = 3'd2;
   localparam logic [2:0] SEL_EN   = 3'd3;
   localparam logic [2:0] SEL_MOD  = 3'd4;

   // FSM and captured command
   logic [1:0]                          state_q, state_d;
   logic [3:0]                          op_q, op_d;
   logic [3:0]                          ch_q, ch_d;
   logic [DATAWORD_WIDTH-1:0]           data_q, data_d;

   // Shadow fields
   logic [TUNING_WIDTH-1:0]             sh_tune_q [N_OSC];
   logic [TUNING_WIDTH-1:0]             sh_tune_d [N_OSC];
   logic [WAVE_SELECT_WIDTH-1:0]        sh_wave_q [N_OSC];
   logic [WAVE_SELECT_WIDTH-1:0]        sh_wave_d [N_OSC];
   logic [PULSEWIDTH_WIDTH-1:0]         sh_pw_q   [N_OSC];
   logic [PULSEWIDTH_WIDTH-1:0]         sh_pw_d   [N_OSC];
   logic [N_OSC-1:0]                    sh_en_q, sh_en_d;
   logic [MODULATION_SELECT_WIDTH-1:0]  sh_mod_q, sh_mod_d;

   // Active fields driving the outputs
   logic [TUNING_WIDTH-1:0]             act_tune_q [N_OSC];
   logic [TUNING_WIDTH-1:0]             act_tune_d [N_OSC];
   logic [WAVE_SELECT_WIDTH-1:0]        act_wave_q [N_OSC];
   logic [WAVE_SELECT_WIDTH-1:0]        act_wave_d [N_OSC];
   logic [PULSEWIDTH_WIDTH-1:0]         act_pw_q   [N_OSC];
   logic [PULSEWIDTH_WIDTH-1:0]         act_pw_d   [N_OSC];
   logic [N_OSC-1:0]                    act_en_q, act_en_d;
   logic [MODULATION_SELECT_WIDTH-1:0]  act_mod_q, act_mod_d;

   logic [DATAWORD_WIDTH-1:0]           rd_data_q, rd_data_d;

   logic                                ch_oob;
   logic                                sel_bad;
   logic                                cmd_ill;
   logic [DATAWORD_WIDTH-1:0]           rd_sel_val;

   // ---------------------------------------------------------------------------
   // Command legality. The channel index is 4 bits wide but only N_OSC
   // channels exist; SET_MOD, NOP and COMMIT ignore the channel field.
   // ---------------------------------------------------------------------------
   assign ch_oob  = ({1'b0, ch_q} >= 5'(N_OSC));
   assign sel_bad = (data_q[2:0] > SEL_MOD);

   always_comb begin
      cmd_ill = 1'b0;
      case (op_q)
         OP_SET_TUNE, OP_SET_WAVE, OP_SET_PW, OP_SET_EN: cmd_ill = ch_oob;
         OP_READ:                                        cmd_ill = ch_oob | sel_bad;
         OP_NOP, OP_SET_MOD, OP_COMMIT:                  cmd_ill = 1'b0;
         default:                                        cmd_ill = 1'b1;
      endcase
   end

   // Readback mux over the shadow fields, zero-extended to the data width
   always_comb begin
      rd_sel_val = '0;
      for (int i = 0; i < N_OSC; i++) begin
         if (ch_q == 4'(i)) begin
            case (data_q[2:0])
               SEL_TUNE: rd_sel_val = DATAWORD_WIDTH'(sh_tune_q[i]);
               SEL_WAVE: rd_sel_val = DATAWORD_WIDTH'(sh_wave_q[i]);
               SEL_PW:   rd_sel_val = DATAWORD_WIDTH'(sh_pw_q[i]);
               SEL_EN:   rd_sel_val = DATAWORD_WIDTH'(sh_en_q[i]);
               SEL_MOD:  rd_sel_val = DATAWORD_WIDTH'(sh_mod_q);
               default:  rd_sel_val = '0;
            endcase
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d    = state_q;
      op_d       = op_q;
      ch_d       = ch_q;
      data_d     = data_q;
      sh_tune_d  = sh_tune_q;
      sh_wave_d  = sh_wave_q;
      sh_pw_d    = sh_pw_q;
      sh_en_d    = sh_en_q;
      sh_mod_d   = sh_mod_q;
      act_tune_d = act_tune_q;
      act_wave_d = act_wave_q;
      act_pw_d   = act_pw_q;
      act_en_d   = act_en_q;
      act_mod_d  = act_mod_q;
      rd_data_d  = rd_data_q;

      case (state_q)
         ST_IDLE: begin
            if (cmd_valid) begin
               op_d    = cmd_word[7:4];
               ch_d    = cmd_word[3:0];
               data_d  = data_word;
               state_d = ST_EXEC;
            end
         end

         ST_EXEC: begin
            state_d = ST_IDLE;
            // Illegal commands fall through with every register untouched
            if (!cmd_ill) begin
               case (op_q)
                  OP_SET_TUNE: begin
                     for (int i = 0; i < N_OSC; i++) begin
                        if (ch_q == 4'(i)) begin
                           sh_tune_d[i] = TUNING_WIDTH'(data_q);
                           if (AUTO_COMMIT != 0) act_tune_d[i] = TUNING_WIDTH'(data_q);
                        end
                     end
                  end
                  OP_SET_WAVE: begin
                     for (int i = 0; i < N_OSC; i++) begin
                        if (ch_q == 4'(i)) begin
                           sh_wave_d[i] = WAVE_SELECT_WIDTH'(data_q);
                           if (AUTO_COMMIT != 0) act_wave_d[i] = WAVE_SELECT_WIDTH'(data_q);
                        end
                     end
                  end
                  OP_SET_PW: begin
                     for (int i = 0; i < N_OSC; i++) begin
                        if (ch_q == 4'(i)) begin
                           sh_pw_d[i] = PULSEWIDTH_WIDTH'(data_q);
                           if (AUTO_COMMIT != 0) act_pw_d[i] = PULSEWIDTH_WIDTH'(data_q);
                        end
                     end
                  end
                  OP_SET_EN: begin
                     for (int i = 0; i < N_OSC; i++) begin
                        if (ch_q == 4'(i)) begin
                           sh_en_d[i] = data_q[0];
                           if (AUTO_COMMIT != 0) act_en_d[i] = data_q[0];
                        end
                     end
                  end
                  OP_SET_MOD: begin
                     sh_mod_d = MODULATION_SELECT_WIDTH'(data_q);
                     if (AUTO_COMMIT != 0) act_mod_d = MODULATION_SELECT_WIDTH'(data_q);
                  end
                  OP_READ: begin
                     rd_data_d = rd_sel_val;
                     state_d   = ST_RESP;
                  end
                  OP_COMMIT: begin
                     // In auto-commit mode active already tracks shadow
                     if (AUTO_COMMIT == 0) begin
                        act_tune_d = sh_tune_q;
                        act_wave_d = sh_wave_q;
                        act_pw_d   = sh_pw_q;
                        act_en_d   = sh_en_q;
                        act_mod_d  = sh_mod_q;
                     end
                  end
                  default: ;
               endcase
            end
         end

         ST_RESP: begin
            if (rd_ready) state_d = ST_IDLE;
         end

         default: state_d = ST_IDLE;
      endcase
   end

   // ---------------------------------------------------------------------------
   // State registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         state_q    <= ST_IDLE;
         op_q       <= '0;
         ch_q       <= '0;
         data_q     <= '0;
         sh_tune_q  <= '{default: '0};
         sh_wave_q  <= '{default: '0};
         sh_pw_q    <= '{default: '0};
         sh_en_q    <= '0;
         sh_mod_q   <= '0;
         act_tune_q <= '{default: '0};
         act_wave_q <= '{default: '0};
         act_pw_q   <= '{default: '0};
         act_en_q   <= '0;
         act_mod_q  <= '0;
         rd_data_q  <= '0;
      end else begin
         state_q    <= state_d;
         op_q       <= op_d;
         ch_q       <= ch_d;
         data_q     <= data_d;
         sh_tune_q  <= sh_tune_d;
         sh_wave_q  <= sh_wave_d;
         sh_pw_q    <= sh_pw_d;
         sh_en_q    <= sh_en_d;
         sh_mod_q   <= sh_mod_d;
         act_tune_q <= act_tune_d;
         act_wave_q <= act_wave_d;
         act_pw_q   <= act_pw_d;
         act_en_q   <= act_en_d;
         act_mod_q  <= act_mod_d;
         rd_data_q  <= rd_data_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------
   // Gated by reset so ready is low for the whole reset window
   assign cmd_ready         = (state_q == ST_IDLE) & ~sys_rst;
   assign rd_valid          = (state_q == ST_RESP);
   assign rd_data           = rd_data_q;
   assign cmd_err           = (state_q == ST_EXEC) & cmd_ill;
   assign osc_en            = act_en_q;
   assign modulation_select = act_mod_q;

   for (genvar g = 0; g < N_OSC; g++) begin : g_pack
      assign osc_tune[g*TUNING_WIDTH      +: TUNING_WIDTH]      = act_tune_q[g];
      assign osc_wave[g*WAVE_SELECT_WIDTH +: WAVE_SELECT_WIDTH] = act_wave_q[g];
      assign osc_pw[g*PULSEWIDTH_WIDTH    +: PULSEWIDTH_WIDTH]  = act_pw_q[g];
   end

endmodule

// File: tb/tb_cmd_regfile.sv
// Testbench for cmd_regfile: two instances (AUTO_COMMIT=0 and =1) share one
// command stream; a field-level model predicts shadow and both active sets.
module tb_cmd_regfile;
   localparam int N  = 2;
   localparam int DW = 16;
   localparam int TW = 14;
   localparam int WW = 3;
   localparam int PW = 12;
   localparam int MW = 2;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic [7:0]    cmd_word;
   logic [DW-1:0] data_word;
   logic          cmd_valid;
   logic          rd_ready;

   logic          rdy_a, rdy_b, rdv_a, rdv_b, err_a, err_b;
   logic [N-1:0]  en_a, en_b;
   logic [N*TW-1:0] tune_a, tune_b;
   logic [N*WW-1:0] wave_a, wave_b;
   logic [N*PW-1:0] pw_a, pw_b;
   logic [MW-1:0] mod_a, mod_b;
   logic [DW-1:0] rdd_a, rdd_b;

   cmd_regfile #(.N_OSC(N), .DATAWORD_WIDTH(DW), .TUNING_WIDTH(TW), .WAVE_SELECT_WIDTH(WW),
                 .PULSEWIDTH_WIDTH(PW), .MODULATION_SELECT_WIDTH(MW), .AUTO_COMMIT(0)) dut_a (
      .sys_clk(clk), .sys_rst(rst), .cmd_word(cmd_word), .data_word(data_word),
      .cmd_valid(cmd_valid), .cmd_ready(rdy_a), .osc_en(en_a), .osc_tune(tune_a),
      .osc_wave(wave_a), .osc_pw(pw_a), .modulation_select(mod_a), .rd_data(rdd_a),
      .rd_valid(rdv_a), .rd_ready(rd_ready), .cmd_err(err_a));

   cmd_regfile #(.N_OSC(N), .DATAWORD_WIDTH(DW), .TUNING_WIDTH(TW), .WAVE_SELECT_WIDTH(WW),
                 .PULSEWIDTH_WIDTH(PW), .MODULATION_SELECT_WIDTH(MW), .AUTO_COMMIT(1)) dut_b (
      .sys_clk(clk), .sys_rst(rst), .cmd_word(cmd_word), .data_word(data_word),
      .cmd_valid(cmd_valid), .cmd_ready(rdy_b), .osc_en(en_b), .osc_tune(tune_b),
      .osc_wave(wave_b), .osc_pw(pw_b), .modulation_select(mod_b), .rd_data(rdd_b),
      .rd_valid(rdv_b), .rd_ready(rd_ready), .cmd_err(err_b));

   int n_cmp = 0;
   int n_bad = 0;

   // Model: index 0 = shadow, 1 = active (manual commit), 2 = active (auto commit)
   int unsigned m_tune [3][N];
   int unsigned m_wave [3][N];
   int unsigned m_pw   [3][N];
   int unsigned m_en   [3][N];
   int unsigned m_mod  [3];

   typedef struct {
      logic [3:0]  op;
      logic [3:0]  ch;
      logic [15:0] data;
      int          hold;
      bit          exp_err;
      logic [15:0] exp_rd;
   } vec_t;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < 3; k++) begin
         for (int i = 0; i < N; i++) begin
            m_tune[k][i] = 0; m_wave[k][i] = 0; m_pw[k][i] = 0; m_en[k][i] = 0;
         end
         m_mod[k] = 0;
      end
   endtask

   function automatic bit model_illegal(input logic [3:0] op, input logic [3:0] ch, input logic [15:0] d);
      if (op >= 8) return 1'b1;
      if ((op >= 1 && op <= 4) || op == 6) begin
         if (int'(ch) >= N) return 1'b1;
      end
      if (op == 6 && d[2:0] >= 5) return 1'b1;
      return 1'b0;
   endfunction

   task automatic model_apply(input logic [3:0] op, input logic [3:0] ch, input logic [15:0] d,
                              output logic [15:0] erd);
      int c;
      erd = 16'h0;
      c = int'(ch);
      if (model_illegal(op, ch, d)) return;
      case (op)
         1: begin m_tune[0][c] = d & 16'h3FFF; m_tune[2][c] = d & 16'h3FFF; end
         2: begin m_wave[0][c] = d & 16'h7;    m_wave[2][c] = d & 16'h7;    end
         3: begin m_pw[0][c]   = d & 16'hFFF;  m_pw[2][c]   = d & 16'hFFF;  end
         4: begin m_en[0][c]   = d & 16'h1;    m_en[2][c]   = d & 16'h1;    end
         5: begin m_mod[0]     = d & 16'h3;    m_mod[2]     = d & 16'h3;    end
         6: begin
            case (d[2:0])
               0: erd = 16'(m_tune[0][c]);
               1: erd = 16'(m_wave[0][c]);
               2: erd = 16'(m_pw[0][c]);
               3: erd = 16'(m_en[0][c]);
               default: erd = 16'(m_mod[0]);
            endcase
         end
         7: begin
            for (int i = 0; i < N; i++) begin
               m_tune[1][i] = m_tune[0][i]; m_wave[1][i] = m_wave[0][i];
               m_pw[1][i] = m_pw[0][i];     m_en[1][i] = m_en[0][i];
            end
            m_mod[1] = m_mod[0];
         end
         default: ;
      endcase
   endtask

   task automatic compare_all(input string tag);
      logic [63:0] e_t, e_w, e_p, e_e;
      for (int k = 1; k <= 2; k++) begin
         e_t = 0; e_w = 0; e_p = 0; e_e = 0;
         for (int i = 0; i < N; i++) begin
            e_t |= 64'(m_tune[k][i]) << (i*TW);
            e_w |= 64'(m_wave[k][i]) << (i*WW);
            e_p |= 64'(m_pw[k][i])   << (i*PW);
            e_e |= 64'(m_en[k][i])   << i;
         end
         if (k == 1) begin
            check({tag, ".tune_a"}, 64'(tune_a), e_t);
            check({tag, ".wave_a"}, 64'(wave_a), e_w);
            check({tag, ".pw_a"},   64'(pw_a),   e_p);
            check({tag, ".en_a"},   64'(en_a),   e_e);
            check({tag, ".mod_a"},  64'(mod_a),  64'(m_mod[1]));
         end else begin
            check({tag, ".tune_b"}, 64'(tune_b), e_t);
            check({tag, ".wave_b"}, 64'(wave_b), e_w);
            check({tag, ".pw_b"},   64'(pw_b),   e_p);
            check({tag, ".en_b"},   64'(en_b),   e_e);
            check({tag, ".mod_b"},  64'(mod_b),  64'(m_mod[2]));
         end
      end
   endtask

   // Full command transaction. hold < 0 leaves a READ parked in RESP.
   task automatic do_cmd(input logic [3:0] op, input logic [3:0] ch, input logic [15:0] d,
                         input int hold, output bit err_seen, output logic [15:0] rd_seen);
      bit ill;
      logic [15:0] erd;
      int n;
      ill = model_illegal(op, ch, d);
      rd_seen = 16'h0;
      @(negedge clk);
      cmd_word = {op, ch}; data_word = d; cmd_valid = 1'b1;
      n = 0;
      while (!(rdy_a && rdy_b) && n < 20) begin
         @(negedge clk); n++;
      end
      check("ready_idle", {rdy_a, rdy_b}, 2'b11);
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      check("err_exec_a", err_a, ill);
      check("err_exec_b", err_b, ill);
      check("ready_exec", {rdy_a, rdy_b}, 2'b00);
      err_seen = err_a;
      model_apply(op, ch, d, erd);
      @(posedge clk); #1;
      check("err_after", {err_a, err_b}, 2'b00);
      compare_all("post_cmd");
      if (op == 6 && !ill) begin
         check("rdv_resp", {rdv_a, rdv_b}, 2'b11);
         check("rdd_a", rdd_a, erd);
         check("rdd_b", rdd_b, erd);
         rd_seen = rdd_a;
         if (hold >= 0) begin
            for (int h = 0; h < hold; h++) begin
               @(posedge clk); #1;
               check("rdv_hold", {rdv_a, rdv_b}, 2'b11);
               check("rdd_hold", rdd_a, erd);
               check("ready_hold", {rdy_a, rdy_b}, 2'b00);
            end
            @(negedge clk); rd_ready = 1'b1;
            @(posedge clk); #1;
            rd_ready = 1'b0;
            check("rdv_drop", {rdv_a, rdv_b}, 2'b00);
            check("ready_back", {rdy_a, rdy_b}, 2'b11);
         end
      end else begin
         check("rdv_none", {rdv_a, rdv_b}, 2'b00);
         check("ready_idle_after", {rdy_a, rdy_b}, 2'b11);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, ".ready"}, {rdy_a, rdy_b}, 2'b00);
      check({tag, ".rdv"},   {rdv_a, rdv_b}, 2'b00);
      check({tag, ".rdd"},   {rdd_a, rdd_b}, 32'h0);
      check({tag, ".err"},   {err_a, err_b}, 2'b00);
      compare_all(tag);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bit e;
      logic [15:0] r;
      int errs;
      int acc [3];
      int idx, cyc;
      bit was;
      logic [N*TW-1:0] s_tune;
      logic [N*WW-1:0] s_wave;
      logic [N*PW-1:0] s_pw;
      logic [N-1:0]    s_en;
      logic [3:0]  bb_op [3];
      logic [3:0]  bb_ch [3];
      logic [15:0] bb_d  [3];
      vec_t vecs [16];

      rst = 1'b1; cmd_valid = 1'b0; rd_ready = 1'b0; cmd_word = 8'h0; data_word = 16'h0;
      model_reset();
      #12;
      check_reset_outputs("reset");
      @(negedge clk); rst = 1'b0; #1;
      check("ready_release", {rdy_a, rdy_b}, 2'b11);

      // Manual commit: tune stays 0 until COMMIT
      do_cmd(4'd1, 4'd1, 16'h1234, 0, e, r);
      check("tune1_precommit_a", tune_a[27:14], 14'h0);
      check("tune1_auto_b", tune_b[27:14], 14'h1234);
      do_cmd(4'd7, 4'd0, 16'h0, 0, e, r);
      check("tune1_commit_a", tune_a[27:14], 14'h1234);

      // Auto commit: wave low bits only
      do_cmd(4'd2, 4'd0, 16'hFFF5, 0, e, r);
      check("wave0_auto_b", wave_b[2:0], 3'd5);

      // Readback held by rd_ready low for 3 cycles
      do_cmd(4'd3, 4'd0, 16'h0ABC, 0, e, r);
      do_cmd(4'd6, 4'd0, 16'h0002, 3, e, r);
      check("read_pw0", r, 16'h0ABC);

      // Two illegal commands, nothing changes
      s_tune = tune_a; s_wave = wave_a; s_pw = pw_a; s_en = en_a;
      errs = 0;
      do_cmd(4'd4, 4'd3, 16'h0001, 0, e, r); errs += int'(e);
      do_cmd(4'd9, 4'd0, 16'hFFFF, 0, e, r); errs += int'(e);
      check("err_count", errs, 2);
      check("illegal_unchanged", {tune_a, wave_a, pw_a, en_a}, {s_tune, s_wave, s_pw, s_en});

      // Back-to-back with cmd_valid held high
      bb_op = '{4'd1, 4'd1, 4'd3};
      bb_ch = '{4'd0, 4'd1, 4'd1};
      bb_d  = '{16'h0111, 16'h0222, 16'h0333};
      @(negedge clk);
      cmd_word = {bb_op[0], bb_ch[0]}; data_word = bb_d[0]; cmd_valid = 1'b1;
      idx = 0; cyc = 0;
      while (idx < 3 && cyc < 40) begin
         was = rdy_a && rdy_b;
         @(posedge clk); #1;
         if (was) begin
            acc[idx] = cyc;
            model_apply(bb_op[idx], bb_ch[idx], bb_d[idx], r);
            idx++;
            if (idx < 3) begin
               cmd_word = {bb_op[idx], bb_ch[idx]}; data_word = bb_d[idx];
            end else begin
               cmd_valid = 1'b0;
            end
         end
         cyc++;
         @(negedge clk);
      end
      check("b2b_accepted", idx, 3);
      check("b2b_gap01", acc[1] - acc[0], 2);
      check("b2b_gap12", acc[2] - acc[1], 2);
      @(posedge clk); #1;
      compare_all("b2b");
      do_cmd(4'd7, 4'd0, 16'h0, 0, e, r);

      // Table vectors from a clean state
      @(negedge clk); rst = 1'b1; model_reset();
      @(negedge clk); rst = 1'b0;
      vecs[0]  = '{4'd1, 4'd0, 16'hFFFF, 0, 1'b0, 16'h0};
      vecs[1]  = '{4'd6, 4'd0, 16'h0000, 1, 1'b0, 16'h3FFF};
      vecs[2]  = '{4'd2, 4'd1, 16'h000E, 0, 1'b0, 16'h0};
      vecs[3]  = '{4'd6, 4'd1, 16'h0001, 0, 1'b0, 16'h0006};
      vecs[4]  = '{4'd4, 4'd1, 16'h0003, 0, 1'b0, 16'h0};
      vecs[5]  = '{4'd6, 4'd1, 16'h0003, 0, 1'b0, 16'h0001};
      vecs[6]  = '{4'd5, 4'd7, 16'h0006, 0, 1'b0, 16'h0};
      vecs[7]  = '{4'd6, 4'd0, 16'h0004, 0, 1'b0, 16'h0002};
      vecs[8]  = '{4'd6, 4'd0, 16'h0005, 0, 1'b1, 16'h0};
      vecs[9]  = '{4'd6, 4'd2, 16'h0000, 0, 1'b1, 16'h0};
      vecs[10] = '{4'd15, 4'd0, 16'h0000, 0, 1'b1, 16'h0};
      vecs[11] = '{4'd0, 4'd0, 16'h0000, 0, 1'b0, 16'h0};
      vecs[12] = '{4'd7, 4'd0, 16'h0000, 0, 1'b0, 16'h0};
      vecs[13] = '{4'd3, 4'd1, 16'h1FFF, 0, 1'b0, 16'h0};
      vecs[14] = '{4'd6, 4'd1, 16'h0002, 2, 1'b0, 16'h0FFF};
      vecs[15] = '{4'd3, 4'd4, 16'h0055, 0, 1'b1, 16'h0};
      for (int v = 0; v < 16; v++) begin
         do_cmd(vecs[v].op, vecs[v].ch, vecs[v].data, vecs[v].hold, e, r);
         check($sformatf("vec%0d.err", v), e, vecs[v].exp_err);
         if (vecs[v].op == 4'd6 && !vecs[v].exp_err)
            check($sformatf("vec%0d.rd", v), r, vecs[v].exp_rd);
      end

      // Randomized commands against the model
      for (int t = 0; t < 300; t++) begin
         logic [3:0]  rop, rch;
         logic [15:0] rd;
         rop = ($urandom_range(0, 19) < 17) ? 4'($urandom_range(0, 7)) : 4'($urandom_range(8, 15));
         rch = 4'($urandom_range(0, 2));
         rd  = 16'($urandom);
         if (rop == 4'd6) rd[2:0] = 3'($urandom_range(0, 5));
         do_cmd(rop, rch, rd, int'($urandom_range(0, 2)), e, r);
      end

      // Reset while parked in RESP
      do_cmd(4'd1, 4'd0, 16'h2222, 0, e, r);
      do_cmd(4'd6, 4'd0, 16'h0000, -1, e, r);
      @(negedge clk); #1;
      rst = 1'b1;
      #1;
      model_reset();
      check_reset_outputs("rst_resp");
      @(posedge clk);
      @(negedge clk); rst = 1'b0; #1;
      check("ready_after_rst", {rdy_a, rdy_b}, 2'b11);
      @(posedge clk); #1;
      check("idle_after_rst", {rdy_a, rdy_b, rdv_a, rdv_b}, 4'b1100);
      do_cmd(4'd6, 4'd0, 16'h0000, 0, e, r);
      check("read_after_rst", r, 16'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/cmd_regfile.md
CMD_REGFILE -- requirements
Module: cmd_regfile

Interface
REQ-001 The block SHALL have parameter N_OSC, default 2, number of oscillator channels (1..16).
REQ-002 The block SHALL have parameter DATAWORD_WIDTH, default 16, command data width.
REQ-003 The block SHALL have parameter TUNING_WIDTH, default 14, tuning word width per channel.
REQ-004 The block SHALL have parameter WAVE_SELECT_WIDTH, default 3, waveform select width per channel.
REQ-005 The block SHALL have parameter PULSEWIDTH_WIDTH, default 12, pulse width per channel.
REQ-006 The block SHALL have parameter MODULATION_SELECT_WIDTH, default 2, global modulation select width.
REQ-007 The block SHALL have parameter AUTO_COMMIT, default 0; 1 = writes go straight to the active registers.
REQ-008 The block SHALL have one clock and an asynchronous, active-high reset: sys_clk input 1 (rising edge) and sys_rst input 1 (async, active-high).
REQ-009 The block SHALL have these ports:
- cmd_word  input 8: [7:4] opcode, [3:0] channel index.
- data_word  input DATAWORD_WIDTH: payload.
- cmd_valid  input 1: command offered.
- cmd_ready  output 1: command accepted when valid&ready.
- osc_en  output N_OSC: active enables, bit i = channel i.
- osc_tune  output N_OSC*TUNING_WIDTH: active tuning words, channel i at slice i.
- osc_wave  output N_OSC*WAVE_SELECT_WIDTH: active waveform selects.
- osc_pw  output N_OSC*PULSEWIDTH_WIDTH: active pulse widths.
- modulation_select  output MODULATION_SELECT_WIDTH: active modulation select.
- rd_data  output DATAWORD_WIDTH: readback value, zero-extended.
- rd_valid  output 1: readback response valid.
- rd_ready  input 1: readback consumed.
- cmd_err  output 1: one-cycle pulse for an illegal command.

Function
REQ-010 The FSM SHALL have states IDLE, EXEC and RESP; cmd_ready = 1 only in IDLE.
REQ-011 In IDLE, when cmd_valid=1 the block SHALL register cmd_word and data_word and go to EXEC; cmd_valid=0 keeps it in IDLE.
REQ-012 Opcodes SHALL be: 0 NOP; 1 SET_TUNE; 2 SET_WAVE; 3 SET_PW; 4 SET_EN (data[0]); 5 SET_MOD (channel ignored); 6 READ; 7 COMMIT; 8-15 illegal.
REQ-013 Each SET_x in EXEC SHALL load the low bits of the data word into that channel's shadow field, with higher data bits ignored.
REQ-014 With AUTO_COMMIT=0, active outputs SHALL change only on COMMIT, which copies all shadow fields of all channels plus modulation to active in EXEC.
REQ-015 With AUTO_COMMIT=1, each SET_x SHALL update shadow and active together in EXEC; COMMIT is then a legal no-op.
REQ-016 Write latency SHALL be: command accepted at edge k, register (shadow or active) updated at edge k+1, FSM back in IDLE after edge k+1.
REQ-017 READ SHALL use data[2:0] to select the shadow field of the channel: 0 tune, 1 wave, 2 pw, 3 en, 4 modulation.
REQ-018 For READ, EXEC SHALL load rd_data and enter RESP with rd_valid=1.
REQ-019 rd_valid and rd_data SHALL hold in RESP until rd_ready=1; at that edge the FSM returns to IDLE and rd_valid drops.
REQ-020 Illegal cases SHALL be: opcode 8-15, channel >= N_OSC for opcodes 1-4 and 6, or READ select 5-7.
REQ-021 An illegal command SHALL pulse cmd_err for the EXEC cycle, modify no register, produce no read response, and return to IDLE.
REQ-022 NOP SHALL spend one cycle in EXEC with no other effect.
REQ-023 In EXEC or RESP, cmd_valid SHALL be ignored; the command stays pending at the source until cmd_ready is 1.

Reset
REQ-024 While sys_rst=1, every output and register SHALL clear immediately (async): shadow and active fields 0, osc_en 0, modulation_select 0, rd_data 0, rd_valid 0, cmd_err 0, FSM IDLE.
REQ-025 cmd_ready SHALL be 0 while sys_rst=1 and 1 on the first cycle after release.
REQ-026 Reset asserted in EXEC or RESP SHALL abort the command with no partial update surviving.

Verification
REQ-027 The bench SHALL cover these scenarios:
- N_OSC=2, AUTO_COMMIT=0: SET_TUNE ch1 0x1234 -> osc_tune[27:14] stays 0; after COMMIT it is 0x1234.
- AUTO_COMMIT=1: SET_WAVE ch0 data 0xFFF5 -> osc_wave[2:0]=5 one edge after acceptance.
- SET_PW ch0 0x0ABC then READ ch0 sel 2 with rd_ready held 0 for 3 cycles -> rd_valid=1, rd_data=0x0ABC stable; cmd_ready=0 until the rd_ready handshake.
- N_OSC=2: SET_EN ch3, then opcode 9 -> cmd_err pulses twice, all outputs unchanged.
- Back-to-back cmd_valid held high with 3 writes -> each accepted every 2 cycles, none lost or duplicated.
- sys_rst asserted mid-RESP -> rd_valid 0 immediately, all fields 0, cmd_ready 1 after release.
